// File: rtl/mem_accum_sequencer.sv
// mem_accum_sequencer: walks a synchronous memory from a start address, summing words until a zero terminator or a full wrap.
module mem_accum_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W:0]   count,
  output logic              ovf
);
  typedef enum logic [1:0] {IDLE, READ, ACC, DONE} state_t;
  state_t state;
  logic [DATA_W:0] sum;
  logic [ADDR_W:0] count_nxt;
  assign sum = {1'b0, out} + {1'b0, mem_data};
  assign count_nxt = count + (ADDR_W+1)'(1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      out <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= READ;
          mem_addr <= start_address;
          mem_rd <= 1'b1;
          busy <= 1'b1;
          out <= '0;
          count <= '0;
          ovf <= 1'b0;
        end
        READ: begin
          state <= ACC;
          mem_rd <= 1'b0;
        end
        ACC: if (mem_data == '0) begin
          state <= DONE;
          done <= 1'b1;
        end else begin
          out <= sum[DATA_W-1:0];
          ovf <= ovf | sum[DATA_W];
          count <= count_nxt;
          mem_addr <= mem_addr + ADDR_W'(1);
          // top bit of count set means every address has been read once
          state <= count_nxt[ADDR_W] ? DONE : READ;
          done <= count_nxt[ADDR_W];
          mem_rd <= ~count_nxt[ADDR_W];
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_accum_sequencer.sv
// tb_mem_accum_sequencer: directed walks over a behavioural 1-cycle-latency memory.
module tb_mem_accum_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0] start_address = '0;
  logic [15:0] mem_data = '0;
  logic [3:0] mem_addr;
  logic mem_rd, busy, done, ovf;
  logic [15:0] out_w;
  logic [4:0] count;
  logic [15:0] mem [16];
  int total = 0;
  int bad = 0;

  mem_accum_sequencer #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd), .busy(busy),
    .done(done), .out(out_w), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic walk(input string tag, input logic [3:0] sa, input int inj, input int rst_at,
                      input int exp_k, input int exp_reads, input logic [15:0] exp_out,
                      input logic [4:0] exp_cnt, input logic exp_ovf);
    logic [3:0] addrs[$];
    int dk = -1;
    int ndone = 0;
    logic [3:0] ea;
    start_address = sa;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 0) check({tag, " busy_rise"}, busy, 1);
      if (mem_rd) addrs.push_back(mem_addr);
      if (done) begin
        if (dk < 0) dk = k;
        ndone++;
      end
      if (k == inj) begin
        start = 1'b1;
        start_address = 4'd2;
      end else if (k == inj + 1) start = 1'b0;
      if (k == rst_at) reset = 1'b0;
      if (k == rst_at + 1) begin
        check({tag, " rst_outs"}, {out_w, count, ovf, done, busy, mem_rd, mem_addr}, 0);
        reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, " done_edge"}, dk, exp_k);
    check({tag, " done_pulses"}, ndone, (exp_k >= 0) ? 1 : 0);
    check({tag, " out"}, out_w, exp_out);
    check({tag, " count"}, count, exp_cnt);
    check({tag, " ovf"}, ovf, exp_ovf);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " reads"}, addrs.size(), exp_reads);
    ea = sa;
    foreach (addrs[i]) begin
      check({tag, " addr"}, addrs[i], ea);
      ea = ea + 4'd1;
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0;
    mem[5] = 16'd3; mem[6] = 16'd4; mem[7] = 16'd0;
    mem[9] = 16'd0;
    mem[14] = 16'd1; mem[15] = 16'd2; mem[0] = 16'd3; mem[1] = 16'd0;
    start = 1'b1;
    start_address = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_w, count, ovf, done, busy, mem_rd, mem_addr}, 0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_no_rd", mem_rd, 0);
    walk("basic", 4'd5, -10, -10, 6, 3, 16'd7, 5'd2, 1'b0);
    walk("immediate", 4'd9, -10, -10, 2, 1, 16'd0, 5'd0, 1'b0);
    walk("wrap", 4'd14, -10, -10, 8, 4, 16'd6, 5'd3, 1'b0);
    walk("start_busy", 4'd5, 1, -10, 6, 3, 16'd7, 5'd2, 1'b0);
    walk("rst_mid", 4'd14, -10, 4, -1, 3, 16'd0, 5'd0, 1'b0);
    walk("after_rst", 4'd5, -10, -10, 6, 3, 16'd7, 5'd2, 1'b0);
    foreach (mem[i]) mem[i] = 16'h1000;
    walk("full_ovf", 4'd0, -10, -10, 32, 16, 16'h0000, 5'd16, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_accum_sequencer.md
# mem_accum_sequencer

Control-and-accumulate sequencer that walks a 16-entry × 16-bit synchronous memory from a given start address. It sums consecutive words until it reads a zero terminator or has read a full memory's worth of words, then reports the sum, word count and overflow with a one-cycle `done` pulse. It sits between the top-level `start`/`start_address` stimulus and the memory of the `main_module` datapath. It drives the memory's read address and read strobe, and produces the 16-bit `out` result.

## Interface
- `ADDR_W`, 4: memory address width; memory depth is 2^ADDR_W.
- `DATA_W`, 16: memory word width and accumulator width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  begin a walk; sampled only in IDLE.
- `start_address`  in  ADDR_W  first address to read; captured on the accepted `start`.
- `mem_data`  in  DATA_W  memory read data; valid in the cycle after `mem_rd`=1.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rd`  out  1  memory read strobe.
- `busy`  out  1  high from the cycle after an accepted `start` until the DONE cycle, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `out`  out  DATA_W  accumulated sum; holds its value until the next accepted `start`.
- `count`  out  ADDR_W+1  number of words added (0..16).
- `ovf`  out  1  sticky carry-out of the accumulator for the current walk.

## Operation
- States:
  - IDLE.
  - READ: `mem_rd`=1, `mem_addr`=current pointer.
  - ACC: `mem_data` is valid and is evaluated.
  - DONE.
- Transitions:
  - IDLE & `start`=1 → READ. On that edge: pointer←`start_address`, `out`←0, `count`←0, `ovf`←0.
  - IDLE & `start`=0 → IDLE.
  - READ → ACC, unconditionally.
  - ACC, `mem_data`==0 → DONE. The terminator is not added and `count` is unchanged.
  - ACC, `mem_data`≠0:
    - `out`←`out`+`mem_data` mod 2^16, `ovf`←`ovf` | carry, `count`←`count`+1, pointer←pointer+1 mod 16.
    - If the new `count` is 16 → DONE; otherwise → READ.
  - DONE → IDLE; `done`=1 for this cycle only.
- `start` in any state other than IDLE is ignored. It does not restart, queue or change the captured address.
- The pointer wraps 15→0. A walk never reads more than 16 words, so no address is added twice.
- `mem_addr` shows the pointer in every state. `mem_rd` is 1 only in READ.
- `out`, `count` and `ovf` are registered and stable from DONE until the next accepted `start`.

## Timing
- Reset (`reset`=0 at a rising edge):
  - Next state is IDLE.
  - `out`=0, `count`=0, `ovf`=0, `done`=0, `busy`=0, `mem_rd`=0, `mem_addr`=0.
  - Reset takes priority over every transition, including mid-walk and during DONE. No `done` pulse follows an aborted walk.
- Memory model: synchronous read with 1-cycle latency. The address presented in READ returns data in the following ACC cycle.
- Each word costs 2 cycles (READ + ACC).
- Let E0 be the edge that samples `start`=1. For N nonzero words followed by a terminator, `done`=1 in the cycle after edge E0+2N+2.
  - N=0 (first word is zero): `done` after edge E0+2.
  - No terminator within 16 words: `done` after edge E0+32.
- `busy` rises after E0 and falls after the DONE cycle.
- A new `start` is accepted at the earliest in the IDLE cycle following DONE.

## Test plan
- Basic walk:
  - mem[5]=3, mem[6]=4, mem[7]=0; `start_address`=5, `start` pulsed for 1 cycle.
  - Expect `mem_addr` sequence 5,6,7 with `mem_rd` pulses; `done` after E0+6; `out`=7, `count`=2, `ovf`=0.
- Immediate terminator:
  - mem[9]=0, `start_address`=9.
  - Expect one read at address 9; `done` after E0+2; `out`=0, `count`=0.
- Wrap-around:
  - mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=0, `start_address`=14.
  - Expect addresses 14,15,0,1; `out`=6, `count`=3, `done` after E0+8.
- Full memory with overflow:
  - All 16 words = 16'h1000, `start_address`=0.
  - Expect 16 reads; `done` after E0+32; `out`=16'h0000, `count`=16, `ovf`=1.
- Start while busy:
  - Rerun the basic walk, then drive `start`=1 with `start_address`=2 during ACC of the first word.
  - Expect identical results to the basic walk and exactly one `done` pulse.
- Reset mid-walk:
  - Assert `reset`=0 for 1 cycle during the third READ of the wrap-around walk.
  - Expect all outputs at their reset values on the next cycle and no `done` pulse.
  - Then a fresh `start` with `start_address`=5 (basic-walk memory contents) gives `out`=7, `count`=2.
